// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler
//   Round-robin scheduler that shares one 8x1 mux output channel between eight
//   requesters. A grant is held for a burst of up to BURST_LEN beats, and each
//   beat is handed downstream over a valid/ready handshake.
//
// Ports
//   clk         single clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   req[7:0]    level request per input, held while the source has data
//   din         flattened inputs, input i = din[i*DW +: DW]
//   gnt[7:0]    registered one-hot grant, all zero when idle
//   sel[2:0]    registered mux select, index of the granted input
//   dout        din[sel] (combinational 8x1 mux)
//   dout_valid  beat available: in XFER and the granted input still requesting
//   dout_ready  sink accepts; a beat transfers on dout_valid & dout_ready
//   busy        high while a burst is in progress
module mux8_rr_scheduler #(
   parameter int unsigned DW        = 8,
   parameter int unsigned BURST_LEN = 4   // legal range 1..255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      req,
   input  logic [8*DW-1:0] din,
   output logic [7:0]      gnt,
   output logic [2:0]      sel,
   output logic [DW-1:0]   dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            busy
);

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   state_t     state;
   logic [7:0] beat_cnt;
   logic [2:0] ptr;

   logic       pick_found;
   logic [2:0] pick_idx;
   logic [2:0] scan_idx;

   // Scan ptr, ptr+1, ... with 3-bit wraparound; first requester wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr;
      scan_idx   = ptr;
      for (int unsigned k = 0; k < 8; k++) begin
         scan_idx = ptr + 3'(k);
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   assign dout       = din[int'(sel) * DW +: DW];
   assign busy       = (state == XFER);
   // Validity follows the live request so an early release drops valid at once.
   assign dout_valid = (state == XFER) & req[sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         beat_cnt <= '0;
         ptr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  sel      <= pick_idx;
                  gnt      <= 8'(1) << pick_idx;
                  beat_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (!req[sel]) begin
                  // Source ran dry: release without counting a beat.
                  state <= IDLE;
                  gnt   <= '0;
                  ptr   <= sel + 3'd1;
               end else if (dout_ready) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state    <= IDLE;
                     gnt      <= '0;
                     ptr      <= sel + 3'd1;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule
